// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, clock glitch filter, frame FSM
// with parity/stop/watchdog checking, and a show-ahead receive FIFO.
module ps2_rx_fifo #(
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ps2_c,
  input  logic                               ps2_d,
  input  logic                               tx_idle,
  input  logic                               rd_en,
  output logic [DATA_BITS-1:0]               rd_data,
  output logic                               rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               rx_done,
  output logic                               parity_err,
  output logic                               frame_err,
  output logic                               timeout_err,
  output logic                               overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic dec);
    if (inc && !dec && cnt != CNT_W'(FIFO_DEPTH)) return cnt + CNT_W'(1);
    if (dec && !inc && cnt != '0)                 return cnt - CNT_W'(1);
    return cnt;
  endfunction

  logic             c_meta_p0, c_sync_p1, d_meta_p0, d_sync_p1;
  logic             c_flt, c_flt_dly, fe;
  logic [FLT_W-1:0] flt_cnt;

  state_t                state, state_nx;
  logic [DATA_BITS-1:0]  shift_q, shift_nx;
  logic                  par_q, par_nx;
  logic [BIT_W-1:0]      bit_cnt, bit_nx;
  logic [WD_W-1:0]       wd_cnt;
  logic                  timeout_hit, good, perr, ferr;

  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full, push, pop, drop;

  // Stage p0/p1: two-flop synchronisers, idle-high after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_meta_p0 <= 1'b1;
      c_sync_p1 <= 1'b1;
      d_meta_p0 <= 1'b1;
      d_sync_p1 <= 1'b1;
    end else begin
      c_meta_p0 <= ps2_c;
      c_sync_p1 <= c_meta_p0;
      d_meta_p0 <= ps2_d;
      d_sync_p1 <= d_meta_p0;
    end
  end

  // Filter: clock only moves after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_flt     <= 1'b1;
      c_flt_dly <= 1'b1;
      flt_cnt   <= '0;
    end else begin
      c_flt_dly <= c_flt;
      if (c_sync_p1 == c_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        c_flt   <= c_sync_p1;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FLT_W'(1);
      end
    end
  end

  assign fe = c_flt_dly & ~c_flt;

  // Frame FSM: inhibit dominates, then watchdog abort, then falling-edge work
  always_comb begin
    state_nx    = state;
    shift_nx    = shift_q;
    par_nx      = par_q;
    bit_nx      = bit_cnt;
    good        = 1'b0;
    perr        = 1'b0;
    ferr        = 1'b0;
    timeout_hit = tx_idle && (state != IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    if (!tx_idle || timeout_hit) begin
      state_nx = IDLE;
    end else if (fe) begin
      case (state)
        IDLE: begin
          if (!d_sync_p1) begin
            shift_nx = '0;
            bit_nx   = '0;
            state_nx = DATA;
          end
        end
        DATA: begin
          shift_nx                = shift_q >> 1;
          shift_nx[DATA_BITS-1]   = d_sync_p1;
          bit_nx                  = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) state_nx = PARITY;
        end
        PARITY: begin
          par_nx   = d_sync_p1;
          state_nx = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          if (!d_sync_p1)               ferr = 1'b1;
          else if (!(^{shift_q, par_q})) perr = 1'b1;
          else                          good = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign full = (count == CNT_W'(FIFO_DEPTH));
  assign pop  = rd_en && (count != '0);
  assign push = good && (!full || rd_en);
  assign drop = good && full && !rd_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      wd_cnt     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_nx;
      rx_done    <= good;
      parity_err <= perr;
      frame_err  <= ferr;
      overflow   <= drop;
      if (!tx_idle || state == IDLE || fe || timeout_hit) wd_cnt <= '0;
      else                                                wd_cnt <= wd_cnt + WD_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= sat_count(count, push, pop);
    end
  end

  // Payload storage carries no reset; the head is masked while empty
  always_ff @(posedge clk) begin
    shift_q <= shift_nx;
    par_q   <= par_nx;
    if (push) mem[wr_ptr] <= shift_q;
  end

  assign rd_valid    = (count != '0);
  assign rd_data     = rd_valid ? mem[rd_ptr] : '0;
  assign fifo_count  = count;
  assign timeout_err = timeout_hit;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are bit-banged on the raw pins and
// every outcome is compared against hand-derived values.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int H  = 30;
  localparam int FL = 8;
  localparam int TO = 50000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_c = 1'b1;
  logic       ps2_d = 1'b1;
  logic       tx_idle = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       rx_done, parity_err, frame_err, timeout_err, overflow;

  int errors = 0;
  int checks = 0;
  int n_done = 0, n_perr = 0, n_ferr = 0, n_to = 0, n_ovf = 0;

  ps2_rx_fifo dut (
    .clk(clk), .rst(rst), .ps2_c(ps2_c), .ps2_d(ps2_d), .tx_idle(tx_idle),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .rx_done(rx_done), .parity_err(parity_err), .frame_err(frame_err),
    .timeout_err(timeout_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done)     n_done++;
    if (parity_err)  n_perr++;
    if (frame_err)   n_ferr++;
    if (timeout_err) n_to++;
    if (overflow)    n_ovf++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic send_bit(input logic b, input bit glitch, input bit rd_pulse);
    @(negedge clk);
    ps2_d = b;
    if (glitch) begin
      repeat (12) @(negedge clk);
      ps2_c = 1'b0;
      repeat (3) @(negedge clk);
      ps2_c = 1'b1;
      repeat (H - 15) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    ps2_c = 1'b0;
    if (rd_pulse) begin
      repeat (FL + 2) @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (H - FL - 3) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    ps2_c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input bit glitch, input bit rd_at_stop);
    logic [10:0] bits;
    bits = {stop, par, data, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch, (i == 10) && rd_at_stop);
    repeat (H) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] data);
    send_frame(data, ~^data, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && rd_valid; k++) pop_one();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    checks++; if ({rx_done, parity_err, frame_err, timeout_err, overflow} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: got %b want 00000", {rx_done, parity_err, frame_err, timeout_err, overflow}); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic();
    int d0;
    d0 = n_done;
    send_good(8'hA5);
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL a5_rx_done: got %0d pulses want 1", n_done - d0); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL a5_rd_valid: got %b want 1", rd_valid); end
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL a5_rd_data: got %h want a5", rd_data); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL a5_count: got %0d want 1", fifo_count); end
    pop_one();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL a5_pop_valid: got %b want 0", rd_valid); end
    pop_one();
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL empty_pop_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_errors();
    int d0, p0, f0;
    d0 = n_done; p0 = n_perr; f0 = n_ferr;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL par_perr: got %0d want 1", n_perr - p0); end
    checks++; if (n_done - d0 !== 0) begin errors++; $display("FAIL par_done: got %0d want 0", n_done - d0); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL par_count: got %0d want 0", fifo_count); end
    p0 = n_perr;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL stop_ferr: got %0d want 1", n_ferr - f0); end
    f0 = n_ferr;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL stop_par_ferr: got %0d want 1", n_ferr - f0); end
    checks++; if (n_perr - p0 !== 0) begin errors++; $display("FAIL stop_par_perr: got %0d want 0", n_perr - p0); end
    checks++; if (n_done - d0 !== 0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL bad_frames_write: done %0d count %0d want 0 0", n_done - d0, fifo_count); end
  endtask

  task automatic test_back_to_back();
    int d0, o0;
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    exp_a = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_b = '{8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 1; i <= 4; i++) send_good(8'(i));
    d0 = n_done; o0 = n_ovf;
    send_good(8'h05);
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL ovf_done: got %0d want 1", n_done - d0); end
    checks++; if (n_ovf - o0 !== 1) begin errors++; $display("FAIL ovf_pulse: got %0d want 1", n_ovf - o0); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_valid !== 1'b1 || rd_data !== exp_a[i]) begin
        errors++; $display("FAIL ovf_contents[%0d]: got %b/%h want 1/%h", i, rd_valid, rd_data, exp_a[i]); end
      pop_one();
    end
    for (int i = 1; i <= 4; i++) send_good(8'(i));
    o0 = n_ovf;
    send_frame(8'h05, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (n_ovf - o0 !== 0) begin errors++; $display("FAIL rdw_ovf: got %0d want 0", n_ovf - o0); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL rdw_count: got %0d want 4", fifo_count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_valid !== 1'b1 || rd_data !== exp_b[i]) begin
        errors++; $display("FAIL rdw_contents[%0d]: got %b/%h want 1/%h", i, rd_valid, rd_data, exp_b[i]); end
      pop_one();
    end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      errors++; $display("FAIL rdw_empty: got %b/%h want 0/00", rd_valid, rd_data); end
  endtask

  task automatic test_timeout();
    int t0, d0, n, fired_at;
    logic [3:0] part;
    part = 4'b1101;
    t0 = n_to;
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(part[i], 1'b0, 1'b0);
    @(negedge clk);
    ps2_d = part[3];
    repeat (H) @(negedge clk);
    ps2_c = 1'b0;
    n = 0;
    fired_at = -1;
    while (n < TO + FL + 30) begin
      @(negedge clk);
      n++;
      if (timeout_err === 1'b1 && fired_at < 0) fired_at = n;
      if (n == H) ps2_c = 1'b1;
    end
    checks++; if (fired_at !== TO + FL + 2) begin
      errors++; $display("FAIL timeout_time: got cycle %0d want %0d", fired_at, TO + FL + 2); end
    checks++; if (n_to - t0 !== 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", n_to - t0); end
    d0 = n_done;
    send_good(8'h3C);
    checks++; if (n_done - d0 !== 1 || rd_data !== 8'h3C) begin
      errors++; $display("FAIL after_timeout_3c: done %0d data %h want 1 3c", n_done - d0, rd_data); end
    drain();
  endtask

  task automatic test_inhibit();
    int d0, p0, f0, t0;
    d0 = n_done; p0 = n_perr; f0 = n_ferr; t0 = n_to;
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tx_idle = 1'b0;
    send_bit(1'b1, 1'b0, 1'b0);
    repeat (100 - 2 * H - 2) @(negedge clk);
    tx_idle = 1'b1;
    repeat (H) @(negedge clk);
    send_good(8'h77);
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL inhibit_done: got %0d want 1", n_done - d0); end
    checks++; if ((n_perr - p0) + (n_ferr - f0) + (n_to - t0) !== 0) begin
      errors++; $display("FAIL inhibit_err_pulses: got %0d want 0", (n_perr - p0) + (n_ferr - f0) + (n_to - t0)); end
    checks++; if (rd_data !== 8'h77 || fifo_count !== 3'd1) begin
      errors++; $display("FAIL inhibit_77: data %h count %0d want 77 1", rd_data, fifo_count); end
    drain();
  endtask

  task automatic test_glitch_reset();
    int d0;
    d0 = n_done;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (n_done - d0 !== 1 || rd_data !== 8'h5A) begin
      errors++; $display("FAIL glitch_5a: done %0d data %h want 1 5a", n_done - d0, rd_data); end
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    ps2_c = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || fifo_count !== 3'd0 || rd_data !== 8'h00) begin
      errors++; $display("FAIL async_reset_fifo: got %b/%0d/%h want 0/0/00", rd_valid, fifo_count, rd_data); end
    checks++; if ({rx_done, parity_err, frame_err, timeout_err, overflow} !== 5'b0) begin
      errors++; $display("FAIL async_reset_pulses: got %b want 00000", {rx_done, parity_err, frame_err, timeout_err, overflow}); end
    repeat (4) @(negedge clk);
    ps2_c = 1'b1;
    ps2_d = 1'b1;
    rst = 1'b1;
    repeat (H) @(negedge clk);
    d0 = n_done;
    send_good(8'h21);
    checks++; if (n_done - d0 !== 1 || rd_data !== 8'h21 || fifo_count !== 3'd1) begin
      errors++; $display("FAIL post_reset_21: done %0d data %h count %0d want 1 21 1", n_done - d0, rd_data, fifo_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_back_to_back();
    test_timeout();
    test_inhibit();
    test_glitch_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
